tm_host_sequencer: RTL and testbench

TM_HOST_SEQUENCER -- requirements
Module: tm_host_sequencer

---
 rtl/tm_host_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_tm_host_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tm_host_sequencer.sv
// Host-side sequencer for the Turing-machine core: buffers program words,
// replays them over the Next/Done handshake, then clocks the run phase.
module tm_host_sequencer #(
    parameter int DW        = 4,
    parameter int DEPTH     = 64,
    parameter int HOLD      = 4,
    parameter int GAP       = 4,
    parameter int MAX_STEPS = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [DW-1:0]          wr_data,
    input  logic [DW-1:0]          tape_pos,
    input  logic                   start,
    input  logic                   tm_compute_done,
    input  logic [10:0]            tm_display,
    output logic [DW-1:0]          tm_input_data,
    output logic                   tm_next,
    output logic                   tm_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic [10:0]            result,
    output logic                   result_valid,
    output logic                   timeout,
    output logic                   wr_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE, LOAD_HI, LOAD_LO, DONE_HI, DONE_LO, RUN_HI, RUN_LO, FINISH
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      step_q, step_d;
    logic            cd_q, cd_d;
    logic            wr_err_q, wr_err_d;
    logic [10:0]     result_q, result_d;
    logic            rv_q, rv_d;
    logic            to_q, to_d;
    logic            next_q, next_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   in_q, in_d;
    logic            we;
    logic            hold_end, gap_end, cd_now;
    logic [DW-1:0]   buf_q [DEPTH];

    assign hold_end = (cnt_q == 4'(HOLD - 1));
    assign gap_end  = (cnt_q == 4'(GAP - 1));
    assign cd_now   = cd_q | tm_compute_done;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        step_d   = step_q;
        cd_d     = cd_q;
        wr_err_d = wr_err_q;
        result_d = result_q;
        rv_d     = rv_q;
        to_d     = to_q;
        we       = 1'b0;

        if (start) wr_err_d = 1'b0;
        if (wr_en) begin
            if (state_q == IDLE && count_q != FULL) begin
                we      = 1'b1;
                count_d = count_q + ONE;
            end else begin
                wr_err_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: if (start && count_q != '0) begin
                state_d  = LOAD_HI;
                cnt_d    = '0;
                rd_ptr_d = '0;
                step_d   = '0;
                cd_d     = 1'b0;
                rv_d     = 1'b0;
                to_d     = 1'b0;
            end
            LOAD_HI: begin
                cnt_d = cnt_q + 4'd1;
                if (hold_end) begin
                    state_d = LOAD_LO;
                    cnt_d   = '0;
                end
            end
            LOAD_LO: begin
                cnt_d = cnt_q + 4'd1;
                if (gap_end) begin
                    cnt_d    = '0;
                    rd_ptr_d = rd_ptr_q + ONE;
                    state_d  = (rd_ptr_d == count_q) ? DONE_HI : LOAD_HI;
                end
            end
            DONE_HI: begin
                cnt_d = cnt_q + 4'd1;
                if (hold_end) begin
                    state_d = DONE_LO;
                    cnt_d   = '0;
                end
            end
            DONE_LO: begin
                cnt_d = cnt_q + 4'd1;
                if (gap_end) begin
                    state_d = RUN_HI;
                    cnt_d   = '0;
                    step_d  = '0;
                    cd_d    = 1'b0;
                end
            end
            RUN_HI: begin
                cd_d  = cd_now;
                cnt_d = cnt_q + 4'd1;
                if (hold_end) begin
                    state_d = RUN_LO;
                    cnt_d   = '0;
                    step_d  = step_q + 8'd1;
                end
            end
            RUN_LO: begin
                cd_d  = cd_now;
                cnt_d = cnt_q + 4'd1;
                if (gap_end) begin
                    cnt_d = '0;
                    // completion beats the step limit when both land together
                    if (cd_now) begin
                        state_d = FINISH;
                    end else if (step_q == 8'(MAX_STEPS)) begin
                        state_d = FINISH;
                        to_d    = 1'b1;
                    end else begin
                        state_d = RUN_HI;
                    end
                end
            end
            FINISH: begin
                state_d  = IDLE;
                result_d = tm_display;
                rv_d     = 1'b1;
                count_d  = '0;
                cd_d     = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        next_d = (state_d == LOAD_HI) || (state_d == RUN_HI);
        done_d = (state_d == DONE_HI);
        busy_d = (state_d != IDLE);
        unique case (state_d)
            IDLE:    in_d = tape_pos;
            LOAD_HI: in_d = buf_q[rd_ptr_d[AW-1:0]];
            LOAD_LO: in_d = in_q;
            default: in_d = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            step_q   <= '0;
            cd_q     <= 1'b0;
            wr_err_q <= 1'b0;
            result_q <= '0;
            rv_q     <= 1'b0;
            to_q     <= 1'b0;
            next_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            in_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            step_q   <= step_d;
            cd_q     <= cd_d;
            wr_err_q <= wr_err_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            to_q     <= to_d;
            next_q   <= next_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            in_q     <= in_d;
        end
    end

    always_ff @(posedge clock) begin
        if (we) buf_q[count_q[AW-1:0]] <= wr_data;
    end

    assign tm_input_data = in_q;
    assign tm_next       = next_q;
    assign tm_done       = done_q;
    assign busy          = busy_q;
    assign count         = count_q;
    assign result        = result_q;
    assign result_valid  = rv_q;
    assign timeout       = to_q;
    assign wr_err        = wr_err_q;

endmodule

// File: tb/tb_tm_host_sequencer.sv
// Randomised bench for tm_host_sequencer: an abstract model of the
// load/done/run pulse train and a simple machine that raises compute_done.
module tb_tm_host_sequencer;

    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int HOLD  = 2;
    localparam int GAP   = 3;
    localparam int MAXS  = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] tape_pos = '0;
    logic          start = 1'b0;
    logic          tm_compute_done = 1'b0;
    logic [10:0]   tm_display = '0;
    logic [DW-1:0] tm_input_data;
    logic          tm_next, tm_done, busy;
    logic [2:0]    count;
    logic [10:0]   result;
    logic          result_valid, timeout, wr_err;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mbuf[$];
    logic          merr = 1'b0;

    tm_host_sequencer #(
        .DW(DW), .DEPTH(DEPTH), .HOLD(HOLD), .GAP(GAP), .MAX_STEPS(MAXS)
    ) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .tape_pos(tape_pos), .start(start),
        .tm_compute_done(tm_compute_done), .tm_display(tm_display),
        .tm_input_data(tm_input_data), .tm_next(tm_next), .tm_done(tm_done),
        .busy(busy), .count(count), .result(result),
        .result_valid(result_valid), .timeout(timeout), .wr_err(wr_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clock);
        wr_en = 1'b0;
        if (mbuf.size() < DEPTH) mbuf.push_back(d);
        else merr = 1'b1;
    endtask

    // rel: run pulse during which the machine reports completion (0 = never)
    task automatic run_seq(input int rel, input logic [10:0] disp);
        logic       en[$];
        logic       ed[$];
        logic [4:0] edat[$];
        int  k, cyc, pulses;
        logic exp_to, seen_done, prev;
        foreach (mbuf[i]) begin
            repeat (HOLD) begin en.push_back(1); ed.push_back(0);
                edat.push_back({1'b1, mbuf[i]}); end
            repeat (GAP) begin en.push_back(0); ed.push_back(0);
                edat.push_back({1'b1, mbuf[i]}); end
        end
        repeat (HOLD) begin en.push_back(0); ed.push_back(1);
            edat.push_back(5'h10); end
        repeat (GAP) begin en.push_back(0); ed.push_back(0);
            edat.push_back(5'h00); end
        exp_to = !(rel > 0 && rel <= MAXS);
        k = exp_to ? MAXS : rel;
        repeat (k) begin
            repeat (HOLD) begin en.push_back(1); ed.push_back(0);
                edat.push_back(5'h00); end
            repeat (GAP) begin en.push_back(0); ed.push_back(0);
                edat.push_back(5'h00); end
        end
        en.push_back(0); ed.push_back(0); edat.push_back(5'h00);

        tm_display = disp;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("wr_err_clr", wr_err, 0);
        chk("rv_clr", result_valid, 0);
        cyc = 0; pulses = 0; seen_done = 0; prev = 0;
        while (busy === 1'b1 && cyc < 400) begin
            if (cyc < en.size()) begin
                chk($sformatf("next[%0d]", cyc), tm_next, en[cyc]);
                chk($sformatf("done[%0d]", cyc), tm_done, ed[cyc]);
                if (edat[cyc][4])
                    chk($sformatf("data[%0d]", cyc), tm_input_data,
                        edat[cyc][3:0]);
            end
            if (tm_done) seen_done = 1;
            if (seen_done && tm_next && !prev) begin
                pulses++;
                if (pulses == rel) tm_compute_done = 1'b1;
            end
            prev = tm_next;
            cyc++;
            @(negedge clock);
        end
        tm_compute_done = 1'b0;
        chk("seq_len", cyc, en.size());
        chk("run_pulses", pulses, k);
        chk("result", result, disp);
        chk("result_valid", result_valid, 1);
        chk("timeout", timeout, exp_to);
        chk("count_end", count, 0);
        chk("busy_end", busy, 0);
        mbuf.delete();
        merr = 1'b0;
    endtask

    initial begin
        int n, rel;
        reset = 1'b1;
        tape_pos = 4'h9;
        repeat (2) @(negedge clock);
        chk("rst_next", tm_next, 0);
        chk("rst_done", tm_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_to", timeout, 0);
        chk("rst_wrerr", wr_err, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_tape", tm_input_data, 4'h9);

        // three words, completion on the 4th run pulse
        push(4'h3); push(4'h5); push(4'hA);
        chk("cnt3", count, 3);
        run_seq(4, 11'h2A5);

        // no completion: step limit ends the run
        push(4'h7);
        run_seq(0, 11'h123);

        // completion on the last allowed pulse beats the limit
        push(4'hC); push(4'h1);
        run_seq(MAXS, 11'h7FF);

        // overflow: fifth push is refused
        push(4'h1); push(4'h2); push(4'h3); push(4'h4); push(4'hF);
        chk("full_cnt", count, 4);
        chk("full_err", wr_err, 1);
        run_seq(2, 11'h055);

        // reset in the middle of the second load pulse
        push(4'h6); push(4'hB);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        wr_en = 1'b1; wr_data = 4'hE;
        @(negedge clock);
        wr_en = 1'b0;
        chk("busy_wrerr", wr_err, 1);
        chk("busy_cnt", count, 2);
        repeat (2) @(negedge clock);
        chk("ld2_next", tm_next, 1);
        chk("ld2_data", tm_input_data, 4'hB);
        #2 reset = 1'b1;
        #1;
        chk("async_next", tm_next, 0);
        chk("async_busy", busy, 0);
        chk("async_cnt", count, 0);
        chk("async_err", wr_err, 0);
        @(negedge clock);
        reset = 1'b0;
        mbuf.delete();
        merr = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("empty_busy", busy, 0);
        chk("empty_next", tm_next, 0);

        for (int it = 0; it < 10; it++) begin
            tape_pos = 4'($urandom);
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) push(4'($urandom));
            chk("rnd_cnt", count, mbuf.size());
            chk("rnd_err", wr_err, merr);
            chk("rnd_tape", tm_input_data, tape_pos);
            rel = $urandom_range(0, 7);
            run_seq(rel, 11'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
